// File: rtl/otp_ctrl_if_arb.sv
// ---------------------------------------------------------------------------
// otp_ctrl_if_arb
//
// Round-robin arbiter that lets NumReq requesters share one OTP macro port.
// Only one OTP transaction is outstanding at a time. The winner's command
// fields are captured when the arbiter leaves idle. Grant and response-valid
// pulses are routed back to that requester only.
//
// Ports
//   clk_i, rst_i        : clock, synchronous active-high reset
//   escalate_en_i       : lc_tx_t escalation; anything but Off (4'b1010) escalates
//   req_i/cmd_i/size_i/wdata_i/addr_i : packed per-requester request bundles
//   gnt_o, rvalid_o     : one-hot grant / response-valid pulses
//   rdata_o, err_o      : shared response payload, zero unless rvalid_o is set
//   otp_*_o             : request to the OTP macro, zero outside ReqSt
//   otp_gnt_i, otp_rvalid_i, otp_rdata_i, otp_err_i : OTP macro handshake
//   idle_o              : high only in IdleSt
//   fsm_err_o           : FSM fault, spurious response or escalation
// ---------------------------------------------------------------------------
module otp_ctrl_if_arb #(
  parameter int NumReq           = 4,
  parameter int OtpIfWidth       = 16,
  parameter int OtpAddrWidth     = 10,
  parameter int OtpSizeWidth     = 2,
  parameter int ScrmblBlockWidth = 64
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [3:0]                       escalate_en_i,
  input  logic [NumReq-1:0]                req_i,
  input  logic [NumReq*2-1:0]              cmd_i,
  input  logic [NumReq*OtpSizeWidth-1:0]   size_i,
  input  logic [NumReq*OtpIfWidth-1:0]     wdata_i,
  input  logic [NumReq*OtpAddrWidth-1:0]   addr_i,
  output logic [NumReq-1:0]                gnt_o,
  output logic [NumReq-1:0]                rvalid_o,
  output logic [ScrmblBlockWidth-1:0]      rdata_o,
  output logic [2:0]                       err_o,
  output logic                             otp_req_o,
  output logic [1:0]                       otp_cmd_o,
  output logic [OtpSizeWidth-1:0]          otp_size_o,
  output logic [OtpIfWidth-1:0]            otp_wdata_o,
  output logic [OtpAddrWidth-1:0]          otp_addr_o,
  input  logic                             otp_gnt_i,
  input  logic                             otp_rvalid_i,
  input  logic [ScrmblBlockWidth-1:0]      otp_rdata_i,
  input  logic [2:0]                       otp_err_i,
  output logic                             idle_o,
  output logic                             fsm_err_o
);

  localparam int IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;

  // Sparse encoding: every pair of states differs in at least 4 bits.
  typedef enum logic [5:0] {
    IdleSt  = 6'b101100,
    ReqSt   = 6'b010110,
    WaitSt  = 6'b001011,
    ErrorSt = 6'b110001
  } state_e;

  state_e                  state_q, state_d;
  logic [IdxW-1:0]         winner_q, last_q, pick;
  logic [1:0]              cmd_q;
  logic [OtpSizeWidth-1:0] size_q;
  logic [OtpIfWidth-1:0]   wdata_q;
  logic [OtpAddrWidth-1:0] addr_q;
  logic                    capture, upd_last, escalate;

  // Search starts one past the last served requester and wraps around.
  function automatic logic [IdxW-1:0] rr_pick(input logic [NumReq-1:0] req,
                                              input logic [IdxW-1:0]   last);
    logic [IdxW-1:0] sel;
    logic            found;
    int              idx;
    sel   = last;
    found = 1'b0;
    for (int i = 1; i <= NumReq; i++) begin
      idx = (int'(last) + i) % NumReq;
      if (!found && req[idx]) begin
        sel   = IdxW'(idx);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  assign escalate = (escalate_en_i != 4'b1010);
  assign pick     = rr_pick(req_i, last_q);

  // Next-state and output decode.
  always_comb begin
    state_d     = state_q;
    capture     = 1'b0;
    upd_last    = 1'b0;
    gnt_o       = '0;
    rvalid_o    = '0;
    rdata_o     = '0;
    err_o       = 3'd0;
    otp_req_o   = 1'b0;
    otp_cmd_o   = 2'd0;
    otp_size_o  = '0;
    otp_wdata_o = '0;
    otp_addr_o  = '0;
    idle_o      = 1'b0;
    fsm_err_o   = 1'b0;
    case (state_q)
      IdleSt: begin
        idle_o = 1'b1;
        if (escalate || otp_rvalid_i) begin
          // A response with nothing outstanding is a protocol fault.
          state_d   = ErrorSt;
          fsm_err_o = 1'b1;
        end else if (|req_i) begin
          capture = 1'b1;
          state_d = ReqSt;
        end else begin
          state_d = IdleSt;
        end
      end
      ReqSt: begin
        otp_req_o   = 1'b1;
        otp_cmd_o   = cmd_q;
        otp_size_o  = size_q;
        otp_wdata_o = wdata_q;
        otp_addr_o  = addr_q;
        if (escalate || otp_rvalid_i) begin
          state_d   = ErrorSt;
          fsm_err_o = 1'b1;
        end else if (otp_gnt_i) begin
          gnt_o[winner_q] = 1'b1;
          state_d         = WaitSt;
        end else begin
          state_d = ReqSt;
        end
      end
      WaitSt: begin
        if (escalate) begin
          state_d   = ErrorSt;
          fsm_err_o = 1'b1;
        end else if (otp_rvalid_i) begin
          rvalid_o[winner_q] = 1'b1;
          rdata_o            = otp_rdata_i;
          err_o              = otp_err_i;
          upd_last           = 1'b1;
          state_d            = IdleSt;
        end else begin
          state_d = WaitSt;
        end
      end
      ErrorSt: begin
        // Terminal: responses arriving here are silently dropped.
        fsm_err_o = 1'b1;
        state_d   = ErrorSt;
      end
      default: begin
        fsm_err_o = 1'b1;
        state_d   = ErrorSt;
      end
    endcase
  end

  // State, arbitration pointer and captured request fields.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IdleSt;
      last_q   <= IdxW'(NumReq - 1);
      winner_q <= '0;
      cmd_q    <= 2'd0;
      size_q   <= '0;
      wdata_q  <= '0;
      addr_q   <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        winner_q <= pick;
        cmd_q    <= cmd_i[int'(pick)*2 +: 2];
        size_q   <= size_i[int'(pick)*OtpSizeWidth +: OtpSizeWidth];
        wdata_q  <= wdata_i[int'(pick)*OtpIfWidth +: OtpIfWidth];
        addr_q   <= addr_i[int'(pick)*OtpAddrWidth +: OtpAddrWidth];
      end
      if (upd_last) begin
        last_q <= winner_q;
      end
    end
  end

endmodule

// File: tb/tb_otp_ctrl_if_arb.sv
// ---------------------------------------------------------------------------
// tb_otp_ctrl_if_arb
//
// Directed bench for otp_ctrl_if_arb (default parameters). Inputs change on
// the falling clock edge and outputs are sampled shortly after, well away
// from the rising edge that clocks the DUT.
// ---------------------------------------------------------------------------
module tb_otp_ctrl_if_arb;

  localparam int N  = 4;
  localparam int IW = 16;
  localparam int AW = 10;
  localparam int SW = 2;
  localparam int DW = 64;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic [3:0]      escalate_en_i;
  logic [N-1:0]    req_i;
  logic [N*2-1:0]  cmd_i;
  logic [N*SW-1:0] size_i;
  logic [N*IW-1:0] wdata_i;
  logic [N*AW-1:0] addr_i;
  logic [N-1:0]    gnt_o, rvalid_o;
  logic [DW-1:0]   rdata_o;
  logic [2:0]      err_o;
  logic            otp_req_o;
  logic [1:0]      otp_cmd_o;
  logic [SW-1:0]   otp_size_o;
  logic [IW-1:0]   otp_wdata_o;
  logic [AW-1:0]   otp_addr_o;
  logic            otp_gnt_i, otp_rvalid_i;
  logic [DW-1:0]   otp_rdata_i;
  logic [2:0]      otp_err_i;
  logic            idle_o, fsm_err_o;

  // Per-requester field tables (bench-side expected values).
  logic [1:0]    t_cmd   [N];
  logic [SW-1:0] t_size  [N];
  logic [IW-1:0] t_wdata [N];
  logic [AW-1:0] t_addr  [N];

  int checks   = 0;
  int failures = 0;

  otp_ctrl_if_arb dut (
    .clk_i(clk_i), .rst_i(rst_i), .escalate_en_i(escalate_en_i),
    .req_i(req_i), .cmd_i(cmd_i), .size_i(size_i), .wdata_i(wdata_i),
    .addr_i(addr_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
    .err_o(err_o), .otp_req_o(otp_req_o), .otp_cmd_o(otp_cmd_o),
    .otp_size_o(otp_size_o), .otp_wdata_o(otp_wdata_o),
    .otp_addr_o(otp_addr_o), .otp_gnt_i(otp_gnt_i),
    .otp_rvalid_i(otp_rvalid_i), .otp_rdata_i(otp_rdata_i),
    .otp_err_i(otp_err_i), .idle_o(idle_o), .fsm_err_o(fsm_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [63:0] obs,
                          input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_fields(input int i, input logic [1:0] c,
                            input logic [SW-1:0] s, input logic [IW-1:0] w,
                            input logic [AW-1:0] a);
    t_cmd[i] = c; t_size[i] = s; t_wdata[i] = w; t_addr[i] = a;
    cmd_i[i*2 +: 2]     = c;
    size_i[i*SW +: SW]  = s;
    wdata_i[i*IW +: IW] = w;
    addr_i[i*AW +: AW]  = a;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  // Full transaction: called just after a falling edge with the DUT in
  // IdleSt and req_i already driven. gd = cycles otp_gnt_i is withheld.
  task automatic do_txn(input int w, input int gd, input logic [63:0] rd,
                        input logic [2:0] er, input logic [N-1:0] req_after);
    logic [N-1:0] oh;
    oh    = '0;
    oh[w] = 1'b1;
    #1;
    check_eq("idle_before", {63'd0, idle_o}, 64'd1);
    check_eq("otp_req_idle", {63'd0, otp_req_o}, 64'd0);
    @(negedge clk_i);
    for (int c = 0; c < gd; c++) begin
      #1;
      check_eq("otp_req_hold", {63'd0, otp_req_o}, 64'd1);
      check_eq("gnt_early", {60'd0, gnt_o}, 64'd0);
      @(negedge clk_i);
    end
    otp_gnt_i = 1'b1;
    #1;
    check_eq("gnt_onehot", {60'd0, gnt_o}, {60'd0, oh});
    check_eq("otp_req", {63'd0, otp_req_o}, 64'd1);
    check_eq("otp_addr", {54'd0, otp_addr_o}, {54'd0, t_addr[w]});
    check_eq("otp_cmd", {62'd0, otp_cmd_o}, {62'd0, t_cmd[w]});
    check_eq("otp_wdata", {48'd0, otp_wdata_o}, {48'd0, t_wdata[w]});
    check_eq("otp_size", {62'd0, otp_size_o}, {62'd0, t_size[w]});
    @(negedge clk_i);
    otp_gnt_i = 1'b0;
    req_i     = req_after;
    #1;
    check_eq("wait_gnt", {60'd0, gnt_o}, 64'd0);
    check_eq("wait_otp_req", {63'd0, otp_req_o}, 64'd0);
    check_eq("wait_idle", {63'd0, idle_o}, 64'd0);
    otp_rvalid_i = 1'b1;
    otp_rdata_i  = rd;
    otp_err_i    = er;
    #1;
    check_eq("rvalid_onehot", {60'd0, rvalid_o}, {60'd0, oh});
    check_eq("rdata", rdata_o, rd);
    check_eq("err", {61'd0, err_o}, {61'd0, er});
    @(negedge clk_i);
    otp_rvalid_i = 1'b0;
    #1;
    check_eq("rvalid_clear", {60'd0, rvalid_o}, 64'd0);
    check_eq("rdata_gated", rdata_o, 64'd0);
    check_eq("err_gated", {61'd0, err_o}, 64'd0);
  endtask

  initial begin
    rst_i         = 1'b1;
    escalate_en_i = 4'b1010;
    req_i         = '0;
    cmd_i         = '0;
    size_i        = '0;
    wdata_i       = '0;
    addr_i        = '0;
    otp_gnt_i     = 1'b0;
    otp_rvalid_i  = 1'b0;
    otp_rdata_i   = '0;
    otp_err_i     = 3'd0;
    set_fields(0, 2'd0, 2'd0, 16'h1111, 10'h010);
    set_fields(1, 2'd0, 2'd1, 16'h2222, 10'h155);
    set_fields(2, 2'd1, 2'd2, 16'hBEEF, 10'h02A);
    set_fields(3, 2'd2, 2'd3, 16'h4444, 10'h3FF);

    // Reset state
    do_reset();
    #1;
    check_eq("rst_idle", {63'd0, idle_o}, 64'd1);
    check_eq("rst_fsm_err", {63'd0, fsm_err_o}, 64'd0);
    check_eq("rst_gnt", {60'd0, gnt_o}, 64'd0);
    check_eq("rst_rvalid", {60'd0, rvalid_o}, 64'd0);
    check_eq("rst_otp_req", {63'd0, otp_req_o}, 64'd0);
    check_eq("rst_otp_addr", {54'd0, otp_addr_o}, 64'd0);
    check_eq("rst_rdata", rdata_o, 64'd0);
    @(negedge clk_i);

    // Round-robin from reset with all requesting: 0,1,2,3,0
    req_i = 4'b1111;
    do_txn(0, 1, 64'hA0, 3'd0, 4'b1111);
    do_txn(1, 1, 64'hA1, 3'd0, 4'b1111);
    do_txn(2, 1, 64'hA2, 3'd0, 4'b1111);
    do_txn(3, 1, 64'hA3, 3'd0, 4'b1111);
    do_txn(0, 1, 64'hA4, 3'd0, 4'b0000);

    // Single write with grant withheld three cycles
    req_i = 4'b0100;
    do_txn(2, 3, 64'h55, 3'd2, 4'b0000);

    // Response routing to requester 1
    req_i = 4'b0010;
    do_txn(1, 0, 64'hDEAD_BEEF_0123_4567, 3'd1, 4'b0000);

    // Reset while in WaitSt; requester 3 wins (last served was 1)
    req_i = 4'b1000;
    @(negedge clk_i);
    otp_gnt_i = 1'b1;
    #1;
    check_eq("pre_rst_gnt", {60'd0, gnt_o}, 64'h8);
    @(negedge clk_i);
    otp_gnt_i = 1'b0;
    req_i     = '0;
    #1;
    check_eq("pre_rst_wait", {63'd0, idle_o}, 64'd0);
    do_reset();
    #1;
    check_eq("post_rst_idle", {63'd0, idle_o}, 64'd1);
    check_eq("post_rst_fsm_err", {63'd0, fsm_err_o}, 64'd0);
    req_i = 4'b1111;
    do_txn(0, 0, 64'h77, 3'd0, 4'b0000);

    // Escalation in WaitSt; requester 1 wins (last served was 0)
    req_i = 4'b0010;
    @(negedge clk_i);
    otp_gnt_i = 1'b1;
    #1;
    check_eq("esc_gnt", {60'd0, gnt_o}, 64'h2);
    @(negedge clk_i);
    otp_gnt_i     = 1'b0;
    req_i         = '0;
    escalate_en_i = 4'b0101;
    @(negedge clk_i);
    escalate_en_i = 4'b1010;
    #1;
    check_eq("esc_idle", {63'd0, idle_o}, 64'd0);
    check_eq("esc_fsm_err", {63'd0, fsm_err_o}, 64'd1);
    otp_rvalid_i = 1'b1;
    otp_rdata_i  = 64'h1234;
    #1;
    check_eq("esc_rvalid_dropped", {60'd0, rvalid_o}, 64'd0);
    check_eq("esc_rdata_dropped", rdata_o, 64'd0);
    @(negedge clk_i);
    otp_rvalid_i = 1'b0;
    req_i        = 4'b1111;
    @(negedge clk_i);
    #1;
    check_eq("err_otp_req", {63'd0, otp_req_o}, 64'd0);
    check_eq("err_gnt", {60'd0, gnt_o}, 64'd0);
    check_eq("err_sticky", {63'd0, fsm_err_o}, 64'd1);
    req_i = '0;
    do_reset();

    // Spurious response in IdleSt
    otp_rvalid_i = 1'b1;
    #1;
    check_eq("spur_fsm_err", {63'd0, fsm_err_o}, 64'd1);
    check_eq("spur_rvalid", {60'd0, rvalid_o}, 64'd0);
    @(negedge clk_i);
    otp_rvalid_i = 1'b0;
    #1;
    check_eq("spur_idle", {63'd0, idle_o}, 64'd0);
    check_eq("spur_err_state", {63'd0, fsm_err_o}, 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
